// File: rtl/auxpll_pkg.sv
// ============================================================================
//  Module      : auxpll_pkg
//  Description : Shared constants and types for the auxiliary PLL front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package auxpll_pkg;

    localparam int c_div_w   = 8;
    localparam int c_div_min = 2;
    localparam int c_div_def = 16;
    localparam int c_lock_w  = 6;
    localparam int c_lock_th = 32;
    localparam int c_run_th  = 4;

    typedef logic [c_div_w-1:0] ratio_t;

endpackage

`default_nettype wire

// File: rtl/auxpll_lockdet.sv
// ============================================================================
//  Module      : auxpll_lockdet
//  Description : BBPD lock detector counting early/late alternations.
//                Built only when AUXPLL_PD_LOCKDET_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module auxpll_lockdet
    import auxpll_pkg::*;
#(
    parameter int LOCK_W  = c_lock_w,
    parameter int LOCK_TH = c_lock_th,
    parameter int RUN_TH  = c_run_th
) (
    input  logic ckv,
    input  logic nrst,
    input  logic pd,
    input  logic pd_vld,
    input  logic clr,
    output logic lock
);

    localparam logic [LOCK_W-1:0] c_alt_max = '1;
    localparam logic [LOCK_W-1:0] c_alt_th  = LOCK_W'(LOCK_TH);
    localparam logic [3:0]        c_run_max = 4'hF;
    localparam logic [3:0]        c_run_lim = 4'(RUN_TH);

    logic              r_prev;
    logic              r_prev_vld;
    logic [LOCK_W-1:0] r_alt_cnt;
    logic [3:0]        r_run_cnt;
    logic              r_lock;
    logic [LOCK_W-1:0] w_alt_inc;
    logic [3:0]        w_run_inc;

    always_comb begin
        w_alt_inc = (r_alt_cnt == c_alt_max) ? r_alt_cnt : r_alt_cnt + LOCK_W'(1);
        w_run_inc = (r_run_cnt == c_run_max) ? r_run_cnt : r_run_cnt + 4'd1;
    end

    // A ratio change invalidates the history: the next decision only seeds prev.
    always_ff @(posedge ckv or negedge nrst) begin
        if (!nrst) begin
            r_prev     <= 1'b0;
            r_prev_vld <= 1'b0;
            r_alt_cnt  <= '0;
            r_run_cnt  <= '0;
            r_lock     <= 1'b0;
        end else if (clr) begin
            r_prev_vld <= 1'b0;
            r_alt_cnt  <= '0;
            r_run_cnt  <= '0;
            r_lock     <= 1'b0;
        end else if (pd_vld) begin
            r_prev <= pd;
            if (!r_prev_vld) begin
                r_prev_vld <= 1'b1;
            end else if (pd != r_prev) begin
                r_alt_cnt <= w_alt_inc;
                r_run_cnt <= '0;
                if (w_alt_inc >= c_alt_th) begin
                    r_lock <= 1'b1;
                end
            end else if (w_run_inc >= c_run_lim) begin
                r_lock    <= 1'b0;
                r_alt_cnt <= '0;
                r_run_cnt <= '0;
            end else begin
                r_run_cnt <= w_run_inc;
            end
        end
    end

    assign lock = r_lock;

endmodule

`default_nettype wire

// File: rtl/auxpll_pd_prog.sv
// ============================================================================
//  Module      : auxpll_pd_prog
//  Description : Programmable CKV divider with bang-bang phase detector.
//                Optional lock detector under macro AUXPLL_PD_LOCKDET_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module auxpll_pd_prog
    import auxpll_pkg::*;
#(
    parameter int DIV_W   = c_div_w,
    parameter int DIV_DEF = c_div_def
`ifdef AUXPLL_PD_LOCKDET_EN
    ,
    parameter int LOCK_W  = c_lock_w,
    parameter int LOCK_TH = c_lock_th,
    parameter int RUN_TH  = c_run_th
`endif
) (
    input  logic             ckv,
    input  logic             nrst,
    input  logic             refck,
    input  logic [DIV_W-1:0] div_n,
    input  logic             div_ld,
    output logic             div_ack,
    output logic             divck,
    output logic             pd,
    output logic             pd_vld,
    output logic             lock
);

    localparam logic [DIV_W-1:0] c_n_def = DIV_W'(DIV_DEF);
    localparam logic [DIV_W-1:0] c_n_min = DIV_W'(c_div_min);

    logic [DIV_W-1:0] r_n_act;
    logic [DIV_W-1:0] r_cnt;
    logic             r_divck;
    logic             r_pd;
    logic             r_pd_vld;
    logic             r_div_ack;
    logic             w_wrap;
    logic             w_load;
    logic [DIV_W-1:0] w_n_req;
    logic [DIV_W-1:0] w_n_next;
    logic [DIV_W-1:0] w_cnt_next;

    // The ratio in force for the new period is the freshly loaded one, so the
    // counter reload and DIVCK both use w_n_next.
    always_comb begin
        w_wrap     = (r_cnt == '0);
        w_load     = w_wrap && div_ld;
        w_n_req    = (div_n < c_n_min) ? c_n_min : div_n;
        w_n_next   = w_load ? w_n_req : r_n_act;
        w_cnt_next = w_wrap ? (w_n_next - DIV_W'(1)) : (r_cnt - DIV_W'(1));
    end

    // REF is sampled directly: the single flop is the bang-bang decision itself.
    always_ff @(posedge ckv or negedge nrst) begin
        if (!nrst) begin
            r_n_act   <= c_n_def;
            r_cnt     <= c_n_def - DIV_W'(1);
            r_divck   <= 1'b1;
            r_pd      <= 1'b0;
            r_pd_vld  <= 1'b0;
            r_div_ack <= 1'b0;
        end else begin
            r_n_act   <= w_n_next;
            r_cnt     <= w_cnt_next;
            r_divck   <= (w_cnt_next >= (w_n_next >> 1));
            r_pd_vld  <= w_wrap;
            r_div_ack <= w_load;
            if (w_wrap) begin
                r_pd <= refck;
            end
        end
    end

    assign divck   = r_divck;
    assign pd      = r_pd;
    assign pd_vld  = r_pd_vld;
    assign div_ack = r_div_ack;

`ifdef AUXPLL_PD_LOCKDET_EN
    logic w_ratio_chg;

    assign w_ratio_chg = w_load && (w_n_req != r_n_act);

    auxpll_lockdet #(
        .LOCK_W  (LOCK_W),
        .LOCK_TH (LOCK_TH),
        .RUN_TH  (RUN_TH)
    ) u_lockdet (
        .ckv    (ckv),
        .nrst   (nrst),
        .pd     (r_pd),
        .pd_vld (r_pd_vld),
        .clr    (w_ratio_chg),
        .lock   (lock)
    );
`else
    assign lock = 1'b0;
`endif

endmodule

`default_nettype wire
